// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_pkg
// Description : Shared USB device-side constants and types. It holds the
//               standard request codes used by the EP0 request sequencers,
//               the device-state enum, and the SET_ADDRESS sequencer state
//               enum.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_pkg;

    // Standard request codes
    localparam logic [7:0] USB_BREQ_SET_ADDRESS = 8'h05;
    localparam logic [7:0] USB_BMRT_STD_DEV_OUT = 8'h00;

    // Device state as seen by the host. CONFIGURED is reserved for the
    // SET_CONFIGURATION sequencer.
    typedef enum logic [1:0] {
        USB_DEV_DEFAULT    = 2'd0,
        USB_DEV_ADDRESS    = 2'd1,
        USB_DEV_CONFIGURED = 2'd2
    } usb_dev_state_t;

    // SET_ADDRESS sequencer states
    typedef enum logic [1:0] {
        SA_IDLE    = 2'd0,
        SA_PENDING = 2'd1,
        SA_COMMIT  = 2'd2
    } set_addr_state_t;

endpackage
`default_nettype wire

// File: rtl/usb_set_address_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : usb_set_address_ctrl
// Description : Sequences the USB SET_ADDRESS request on EP0. It validates the
//               decoded SETUP fields and holds the new address until the host
//               ACKs the zero-length status IN. It then issues one write to
//               the address register and tracks the DEFAULT/ADDRESS device
//               state. A USB bus reset forces a write of address 0.
//
// Ports       : clk, rst_n         - clock, async active-low reset
//               bus_reset_i        - USB bus reset pulse
//               setup_*_i          - decoded SETUP packet, qualified by
//                                    setup_valid_i
//               status_ack_i       - host ACKed the EP0 status-stage ZLP
//               status_ready_o     - EP0 may answer the status IN with a ZLP
//               req_error_o        - malformed SET_ADDRESS, EP0 must STALL
//               abort_o            - pending address discarded
//               addr_wr_en_o/_data - write port to usb_addr_reg
//               dev_state_o        - 0 = DEFAULT, 1 = ADDRESS
// Revision    : 1.0 - initial release
// ============================================================================
module usb_set_address_ctrl
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 60000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_reset_i,
    input  logic        setup_valid_i,
    input  logic [7:0]  setup_bmrt_i,
    input  logic [7:0]  setup_breq_i,
    input  logic [15:0] setup_wvalue_i,
    input  logic [15:0] setup_windex_i,
    input  logic [15:0] setup_wlength_i,
    input  logic        status_ack_i,
    output logic        status_ready_o,
    output logic        req_error_o,
    output logic        abort_o,
    output logic        addr_wr_en_o,
    output logic [6:0]  addr_wr_data_o,
    output logic        dev_state_o
);

    localparam int               CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
    // The counter equals the number of completed PENDING cycles. Aborting on
    // the edge where it would reach TIMEOUT_CYCLES places abort_o exactly
    // TIMEOUT_CYCLES cycles after status_ready_o rises.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    set_addr_state_t state_q;
    usb_dev_state_t  dev_state_q;
    logic [6:0]      pend_addr_q;
    logic [CNT_W-1:0] cnt_q;
    logic            ready_q;
    logic            error_q;
    logic            abort_q;
    logic            wr_en_q;
    logic [6:0]      wr_data_q;

    logic is_set_addr;
    logic fields_ok;

    assign is_set_addr = (setup_bmrt_i == USB_BMRT_STD_DEV_OUT) &&
                         (setup_breq_i == USB_BREQ_SET_ADDRESS);
    assign fields_ok   = (setup_wvalue_i[15:7] == 9'd0) &&
                         (setup_windex_i == 16'd0) &&
                         (setup_wlength_i == 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SA_IDLE;
            dev_state_q <= USB_DEV_DEFAULT;
            pend_addr_q <= 7'd0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            abort_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= 7'd0;
        end else if (bus_reset_i) begin
            // Bus reset wins over everything and is not reported as an abort.
            state_q     <= SA_IDLE;
            dev_state_q <= USB_DEV_DEFAULT;
            pend_addr_q <= 7'd0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            abort_q     <= 1'b0;
            wr_en_q     <= 1'b1;
            wr_data_q   <= 7'd0;
        end else begin
            error_q   <= 1'b0;
            abort_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= 7'd0;

            // The write strobe is out this cycle, so the address register
            // holds the new address from the next cycle on. dev_state follows
            // the register.
            if (state_q == SA_COMMIT) begin
                dev_state_q <= (pend_addr_q != 7'd0) ? USB_DEV_ADDRESS : USB_DEV_DEFAULT;
                state_q     <= SA_IDLE;
            end

            if (setup_valid_i) begin
                if (is_set_addr && fields_ok) begin
                    // A fresh SET_ADDRESS replaces any pending one. The old
                    // one is reported as discarded.
                    abort_q     <= (state_q == SA_PENDING);
                    pend_addr_q <= setup_wvalue_i[6:0];
                    cnt_q       <= '0;
                    ready_q     <= 1'b1;
                    state_q     <= SA_PENDING;
                end else begin
                    error_q <= is_set_addr;
                    if (state_q == SA_PENDING) begin
                        abort_q <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= SA_IDLE;
                    end
                end
            end else if (state_q == SA_PENDING) begin
                if (status_ack_i) begin
                    ready_q   <= 1'b0;
                    wr_en_q   <= 1'b1;
                    wr_data_q <= pend_addr_q;
                    state_q   <= SA_COMMIT;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    ready_q <= 1'b0;
                    abort_q <= 1'b1;
                    state_q <= SA_IDLE;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign status_ready_o = ready_q;
    assign req_error_o    = error_q;
    assign abort_o        = abort_q;
    assign addr_wr_en_o   = wr_en_q;
    assign addr_wr_data_o = wr_data_q;
    assign dev_state_o    = (dev_state_q == USB_DEV_ADDRESS);

endmodule
`default_nettype wire
